// File: rtl/branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// branch_predictor_btb
//   Branch target buffer with per-entry saturating direction counters.
//   The fetch PC is looked up combinationally. The buffer is trained from ID
//   when a branch or jump resolves. Indexing is either bimodal (PC bits only)
//   or gshare (PC bits XOR a non-speculative global history register).
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   enable           global stall gate; no state changes while low
//   clear            invalidate all entries and the history register
//   lk_pc/lk_valid   fetch PC to look up; lk_valid only feeds perf_lookups
//   pred_*           hit, direction, next PC and the index that was used
//   upd_*            resolved branch: PC, index captured at lookup, outcome,
//                    actual target and mispredict flag
//   perf_lookups     saturating count of enabled lookups
//   perf_mispred     saturating count of enabled mispredicts
// -----------------------------------------------------------------------------
module branch_predictor_btb #(
  parameter int PC_W   = 64,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int MODE   = 0,
  parameter int GHR_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [PC_W-1:0]   lk_pc,
  input  logic              lk_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_lookups,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WEAK_N = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic [PERF_W-1:0] perf_lookups_q, perf_lookups_d;
  logic [PERF_W-1:0] perf_mispred_q, perf_mispred_d;

  logic [IDX_W-1:0]  ghr_ext_s;
  logic [IDX_W-1:0]  lk_idx_s;
  logic              lk_hit_s;
  logic              lk_taken_s;
  logic [TAG_W-1:0]  upd_tag_s;
  logic              upd_hit_s;
  logic [CNT_W-1:0]  cnt_cur_s;
  logic [CNT_W-1:0]  cnt_upd_s;

  // Only word-aligned PC bits take part in indexing and tagging.
  logic unused_bits_s;
  assign unused_bits_s = ^{lk_pc[1:0], upd_pc[IDX_W+1:0]};

  // Lookup: index selection, tag compare, direction and next-PC choice.
  always_comb begin
    ghr_ext_s = '0;
    ghr_ext_s[GHR_W-1:0] = ghr_q;
    if (MODE == 1) begin
      lk_idx_s = lk_pc[IDX_W+1:2] ^ ghr_ext_s;
    end else begin
      lk_idx_s = lk_pc[IDX_W+1:2];
    end
    lk_hit_s   = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_pc[PC_W-1:IDX_W+2]);
    lk_taken_s = lk_hit_s && cnt_q[lk_idx_s][CNT_W-1];
    if (lk_taken_s) begin
      pred_target = target_q[lk_idx_s];
    end else begin
      pred_target = lk_pc + PC_W'(4);
    end
  end

  assign pred_hit   = lk_hit_s;
  assign pred_taken = lk_taken_s;
  assign pred_idx   = lk_idx_s;

  // Training: hit detection at upd_idx and the saturating counter step.
  always_comb begin
    upd_tag_s = upd_pc[PC_W-1:IDX_W+2];
    upd_hit_s = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag_s);
    cnt_cur_s = cnt_q[upd_idx];
    if (upd_taken) begin
      if (cnt_cur_s == CNT_MAX) begin
        cnt_upd_s = cnt_cur_s;
      end else begin
        cnt_upd_s = cnt_cur_s + CNT_W'(1);
      end
    end else begin
      if (cnt_cur_s == CNT_ZERO) begin
        cnt_upd_s = cnt_cur_s;
      end else begin
        cnt_upd_s = cnt_cur_s - CNT_W'(1);
      end
    end
  end

  // Global history next state; history follows resolved outcomes only.
  always_comb begin
    ghr_d = ghr_q;
    if (enable) begin
      if (clear) begin
        ghr_d = '0;
      end else if (upd_valid && (MODE == 1)) begin
        ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
      end else begin
        ghr_d = ghr_q;
      end
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_lookups_d = perf_lookups_q;
    perf_mispred_d = perf_mispred_q;
    if (enable && lk_valid && !(&perf_lookups_q)) begin
      perf_lookups_d = perf_lookups_q + PERF_W'(1);
    end else begin
      perf_lookups_d = perf_lookups_q;
    end
    if (enable && upd_valid && upd_mispredict && !(&perf_mispred_q)) begin
      perf_mispred_d = perf_mispred_q + PERF_W'(1);
    end else begin
      perf_mispred_d = perf_mispred_q;
    end
  end

  // Entry storage: reset beats clear, clear drops any same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WEAK_N;
      end
    end else if (enable) begin
      if (clear) begin
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (upd_valid) begin
        if (upd_hit_s) begin
          cnt_q[upd_idx] <= cnt_upd_s;
          if (upd_taken) begin
            target_q[upd_idx] <= upd_target;
          end
        end else if (upd_taken) begin
          // Taken miss replaces whatever lives at this index.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag_s;
          target_q[upd_idx] <= upd_target;
          cnt_q[upd_idx]    <= CNT_WEAK_T;
        end
      end
    end
  end

  // History and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q          <= '0;
      perf_lookups_q <= '0;
      perf_mispred_q <= '0;
    end else begin
      ghr_q          <= ghr_d;
      perf_lookups_q <= perf_lookups_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_lookups = perf_lookups_q;
  assign perf_mispred = perf_mispred_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_btb
//   Three predictor instances share one stimulus stream:
//     u0: bimodal, 2-bit counters, 32-bit perf
//     u1: gshare, GHR_W=6, 2-bit counters, 32-bit perf
//     u2: gshare, GHR_W=4, 3-bit counters, 4-bit perf
//   A behavioural model per instance predicts every output each cycle.
//   Directed steps pin the model with literal expectations; a random phase
//   follows.
// -----------------------------------------------------------------------------
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst, enable, clear, lk_valid;
  logic [63:0] lk_pc;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [63:0] upd_pc, upd_target;
  logic [5:0]  upd_idx;

  logic        hit_w [3];
  logic        tk_w  [3];
  logic [63:0] tgt_w [3];
  logic [5:0]  idx_w [3];
  logic [31:0] plk0, pmp0, plk1, pmp1;
  logic [3:0]  plk2, pmp2;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.PC_W(64), .IDX_W(6), .CNT_W(2), .MODE(0), .GHR_W(6), .PERF_W(32)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .lk_pc(lk_pc), .lk_valid(lk_valid),
    .pred_hit(hit_w[0]), .pred_taken(tk_w[0]), .pred_target(tgt_w[0]), .pred_idx(idx_w[0]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_lookups(plk0), .perf_mispred(pmp0));

  branch_predictor_btb #(.PC_W(64), .IDX_W(6), .CNT_W(2), .MODE(1), .GHR_W(6), .PERF_W(32)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .lk_pc(lk_pc), .lk_valid(lk_valid),
    .pred_hit(hit_w[1]), .pred_taken(tk_w[1]), .pred_target(tgt_w[1]), .pred_idx(idx_w[1]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_lookups(plk1), .perf_mispred(pmp1));

  branch_predictor_btb #(.PC_W(64), .IDX_W(6), .CNT_W(3), .MODE(1), .GHR_W(4), .PERF_W(4)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .lk_pc(lk_pc), .lk_valid(lk_valid),
    .pred_hit(hit_w[2]), .pred_taken(tk_w[2]), .pred_target(tgt_w[2]), .pred_idx(idx_w[2]),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_lookups(plk2), .perf_mispred(pmp2));

  // Per-instance configuration seen by the model.
  int              c_mode [3] = '{0, 1, 1};
  int              c_gw   [3] = '{6, 6, 4};
  int              c_cw   [3] = '{2, 2, 3};
  longint unsigned c_pmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};

  // Model state: a plain table per instance.
  bit              m_valid [3][64];
  logic [63:0]     m_tag   [3][64];
  logic [63:0]     m_tgt   [3][64];
  int              m_cnt   [3][64];
  int              m_ghr   [3];
  longint unsigned m_plk   [3];
  longint unsigned m_pmp   [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_pred(input int k, input logic [63:0] pc, output logic h,
                            output logic t, output logic [63:0] tg, output int ix);
    ix = int'((pc >> 2) & 64'd63);
    if (c_mode[k] != 0) ix = ix ^ m_ghr[k];
    h  = m_valid[k][ix] && (m_tag[k][ix] == (pc >> 8));
    t  = h && (m_cnt[k][ix] >= (1 << (c_cw[k] - 1)));
    tg = t ? m_tgt[k][ix] : pc + 64'd4;
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int e = 0; e < 64; e++) begin
          m_valid[k][e] = 1'b0;
          m_tag[k][e]   = '0;
          m_tgt[k][e]   = '0;
          m_cnt[k][e]   = (1 << (c_cw[k] - 1)) - 1;
        end
        m_ghr[k] = 0;
        m_plk[k] = 0;
        m_pmp[k] = 0;
      end else if (enable) begin
        if (lk_valid && m_plk[k] < c_pmax[k]) m_plk[k]++;
        if (upd_valid && upd_mispredict && m_pmp[k] < c_pmax[k]) m_pmp[k]++;
        if (clear) begin
          for (int e = 0; e < 64; e++) m_valid[k][e] = 1'b0;
          m_ghr[k] = 0;
        end else if (upd_valid) begin
          int i;
          int cmax;
          i    = int'(upd_idx);
          cmax = (1 << c_cw[k]) - 1;
          if (m_valid[k][i] && m_tag[k][i] == (upd_pc >> 8)) begin
            if (upd_taken) begin
              m_cnt[k][i] = (m_cnt[k][i] < cmax) ? m_cnt[k][i] + 1 : cmax;
              m_tgt[k][i] = upd_target;
            end else begin
              m_cnt[k][i] = (m_cnt[k][i] > 0) ? m_cnt[k][i] - 1 : 0;
            end
          end else if (upd_taken) begin
            m_valid[k][i] = 1'b1;
            m_tag[k][i]   = upd_pc >> 8;
            m_tgt[k][i]   = upd_target;
            m_cnt[k][i]   = 1 << (c_cw[k] - 1);
          end
          if (c_mode[k] != 0)
            m_ghr[k] = ((m_ghr[k] << 1) | int'(upd_taken)) & ((1 << c_gw[k]) - 1);
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare process: every DUT output against the model, every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        logic        eh, et;
        logic [63:0] etg, aplk, apmp;
        int          eix;
        model_pred(k, lk_pc, eh, et, etg, eix);
        aplk = (k == 0) ? 64'(plk0) : (k == 1) ? 64'(plk1) : 64'(plk2);
        apmp = (k == 0) ? 64'(pmp0) : (k == 1) ? 64'(pmp1) : 64'(pmp2);
        chk($sformatf("u%0d_hit", k),    64'(hit_w[k]), 64'(eh));
        chk($sformatf("u%0d_taken", k),  64'(tk_w[k]),  64'(et));
        chk($sformatf("u%0d_target", k), tgt_w[k],      etg);
        chk($sformatf("u%0d_idx", k),    64'(idx_w[k]), 64'(eix));
        chk($sformatf("u%0d_plk", k),    aplk,          m_plk[k]);
        chk($sformatf("u%0d_pmp", k),    apmp,          m_pmp[k]);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; enable = 1'b1; clear = 1'b0; lk_valid = 1'b0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic do_upd(input logic [63:0] pc, input logic [5:0] ix, input logic tk,
                        input logic [63:0] tg);
    upd_pc = pc; upd_idx = ix; upd_taken = tk; upd_target = tg; upd_valid = 1'b1;
    nxt();
    upd_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd_pc();
    logic [63:0] hi;
    int          sel;
    sel = $urandom_range(0, 4);
    hi  = (sel == 4) ? 64'hDEAD_BEEF_0000_0001 : 64'(sel);
    return (hi << 8) | (64'($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    idle();
    rst = 1'b1; lk_pc = 64'h100;
    upd_pc = '0; upd_idx = '0; upd_target = '0;
    nxt(); nxt();
    rst = 1'b0;
    chk_on = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_hit", 64'(hit_w[0]), 64'd0);
    chk("rst_taken", 64'(tk_w[0]), 64'd0);
    chk("rst_target", tgt_w[0], 64'h104);
    chk("rst_idx", 64'(idx_w[0]), 64'd0);
    chk("rst_plk", 64'(plk0), 64'd0);
    chk("rst_pmp", 64'(pmp0), 64'd0);
    nxt();

    // Allocation; not visible in the same cycle.
    upd_pc = 64'h100; upd_idx = 6'd0; upd_taken = 1'b1; upd_target = 64'h200; upd_valid = 1'b1;
    @(negedge clk);
    chk("same_cycle_hit", 64'(hit_w[0]), 64'd0);
    nxt();
    upd_valid = 1'b0;
    @(negedge clk);
    chk("alloc_hit", 64'(hit_w[0]), 64'd1);
    chk("alloc_taken", 64'(tk_w[0]), 64'd1);
    chk("alloc_target", tgt_w[0], 64'h200);
    nxt();

    // Counter saturation low then high.
    for (int i = 0; i < 3; i++) do_upd(64'h100, 6'd0, 1'b0, 64'h0);
    @(negedge clk);
    chk("sat_lo_hit", 64'(hit_w[0]), 64'd1);
    chk("sat_lo_taken", 64'(tk_w[0]), 64'd0);
    chk("sat_lo_target", tgt_w[0], 64'h104);
    nxt();
    for (int i = 0; i < 4; i++) do_upd(64'h100, 6'd0, 1'b1, 64'h200);
    @(negedge clk);
    chk("sat_hi_taken", 64'(tk_w[0]), 64'd1);
    nxt();
    do_upd(64'h100, 6'd0, 1'b0, 64'h0);
    @(negedge clk);
    chk("sat_hi_step_taken", 64'(tk_w[0]), 64'd1);
    nxt();

    // Not-taken miss allocates nothing.
    do_upd(64'h140, 6'd16, 1'b0, 64'h0);
    lk_pc = 64'h140;
    @(negedge clk);
    chk("nt_miss_hit", 64'(hit_w[0]), 64'd0);
    nxt();

    // Alias replacement at index 0.
    do_upd(64'h200, 6'd0, 1'b1, 64'h300);
    lk_pc = 64'h100;
    @(negedge clk);
    chk("alias_old_hit", 64'(hit_w[0]), 64'd0);
    chk("alias_old_target", tgt_w[0], 64'h104);
    #1 lk_pc = 64'h200;
    #1;
    chk("alias_new_hit", 64'(hit_w[0]), 64'd1);
    chk("alias_new_taken", 64'(tk_w[0]), 64'd1);
    chk("alias_new_target", tgt_w[0], 64'h300);
    nxt();

    // Clear with a simultaneous update.
    clear = 1'b1;
    do_upd(64'h100, 6'd0, 1'b1, 64'h500);
    clear = 1'b0;
    lk_pc = 64'h100;
    @(negedge clk);
    chk("clr_drop_hit", 64'(hit_w[0]), 64'd0);
    chk("clr_ghr_idx", 64'(idx_w[1]), 64'd0);
    #1 lk_pc = 64'h200;
    #1;
    chk("clr_inval_hit", 64'(hit_w[0]), 64'd0);
    nxt();

    // Global history: T, T, N -> 3'b110.
    do_upd(64'h414, 6'd5, 1'b1, 64'h440);
    do_upd(64'h414, 6'd5, 1'b1, 64'h440);
    do_upd(64'h414, 6'd5, 1'b0, 64'h0);
    lk_pc = 64'h100;
    @(negedge clk);
    chk("ghr_idx_u1", 64'(idx_w[1]), 64'd6);
    chk("ghr_idx_u2", 64'(idx_w[2]), 64'd6);
    chk("bimodal_idx", 64'(idx_w[0]), 64'd0);
    nxt();

    // enable low blocks clear, update and perf counting.
    enable = 1'b0; clear = 1'b1; lk_valid = 1'b1; upd_mispredict = 1'b1;
    do_upd(64'h100, 6'd0, 1'b1, 64'h900);
    idle();
    lk_pc = 64'h414;
    @(negedge clk);
    chk("en0_keep_hit", 64'(hit_w[0]), 64'd1);
    chk("en0_keep_target", tgt_w[0], 64'h440);
    chk("en0_plk", 64'(plk0), 64'd0);
    chk("en0_pmp", 64'(pmp0), 64'd0);
    #1 lk_pc = 64'h100;
    #1;
    chk("en0_no_upd_hit", 64'(hit_w[0]), 64'd0);
    chk("en0_ghr_idx", 64'(idx_w[1]), 64'd6);
    nxt();

    // Perf saturation: 20 mispredicts and lookups.
    lk_valid = 1'b1; upd_mispredict = 1'b1;
    for (int i = 0; i < 20; i++) do_upd(64'h3C0, 6'd48, 1'b0, 64'h0);
    idle();
    @(negedge clk);
    chk("perf_pmp_wide", 64'(pmp0), 64'd20);
    chk("perf_plk_wide", 64'(plk0), 64'd20);
    chk("perf_pmp_sat", 64'(pmp2), 64'd15);
    chk("perf_plk_sat", 64'(plk2), 64'd15);
    nxt();

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 399) == 0);
      clear          = ($urandom_range(0, 59) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      lk_valid       = 1'($urandom_range(0, 1));
      lk_pc          = rnd_pc();
      upd_valid      = ($urandom_range(0, 2) != 0);
      upd_pc         = rnd_pc();
      upd_idx        = ($urandom_range(0, 1) == 1) ? upd_pc[7:2] : 6'($urandom_range(0, 63));
      upd_taken      = 1'($urandom_range(0, 1));
      upd_mispredict = 1'($urandom_range(0, 1));
      upd_target     = {$urandom, $urandom} & ~64'h3;
      nxt();
    end

    // Reset mid-stream with an update present.
    idle();
    rst = 1'b1; lk_valid = 1'b1; upd_mispredict = 1'b1;
    do_upd(64'h100, 6'd0, 1'b1, 64'h700);
    idle();
    lk_pc = 64'h100;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_hit_u%0d", k), 64'(hit_w[k]), 64'd0);
      chk($sformatf("mid_rst_target_u%0d", k), tgt_w[k], 64'h104);
    end
    chk("mid_rst_idx_u1", 64'(idx_w[1]), 64'd0);
    chk("mid_rst_plk", 64'(plk0), 64'd0);
    chk("mid_rst_pmp", 64'(pmp2), 64'd0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with N-bit saturating direction counters.
- Selectable bimodal or gshare indexing.
- Sits beside the PC in IF: combinational lookup on the fetch PC; trained from ID when a branch/jump resolves.
- Adds target caching, tags, configurable depth/counter width, global history and performance counters.

Parameters:
- PC_W, 64, PC/target width
- IDX_W, 6, index bits; ENTRIES = 2**IDX_W
- CNT_W, 2, saturating counter width (>=1)
- MODE, 0, 0 = bimodal, 1 = gshare
- GHR_W, 6, global history length (<= IDX_W; ignored when MODE=0)
- PERF_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active high
- enable  in  1  global stall gate; no state change when low
- clear  in  1  synchronous invalidate of all entries and GHR
- lk_pc  in  PC_W  fetch PC to look up
- lk_valid  in  1  lookup counted for perf
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  hit and counter MSB set
- pred_target  out  PC_W  predicted next PC
- pred_idx  out  IDX_W  index used; carried down the pipe to the update
- upd_valid  in  1  resolved branch/jump this cycle
- upd_pc  in  PC_W  PC of resolved branch
- upd_idx  in  IDX_W  pred_idx captured at that branch's lookup
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual taken target
- upd_mispredict  in  1  prediction was wrong
- perf_lookups  out  PERF_W  lookup count
- perf_mispred  out  PERF_W  mispredict count

Behaviour:
Storage and indexing:
- Per entry: valid, tag (PC_W-IDX_W-2 bits = pc[PC_W-1:IDX_W+2]), target (PC_W), cnt (CNT_W).
- Index: MODE=0 uses lk_pc[IDX_W+1:2]; MODE=1 uses lk_pc[IDX_W+1:2] XOR zero-extended ghr.

Lookup (combinational, zero latency):
- pred_hit = valid[idx] & tag match.
- pred_taken = pred_hit & cnt[idx][CNT_W-1].
- pred_target = pred_taken ? target[idx] : lk_pc+4.
- No write-to-read bypass: a same-cycle update becomes visible after the edge.

Update (on rising clk, gated by enable & upd_valid), at entry upd_idx:
- Hit (valid & tag of upd_pc match): cnt +1 if taken, -1 if not, saturating at 0 and 2**CNT_W-1. Target overwritten with upd_target when taken.
- Miss, taken: allocate/replace. valid=1, tag, target, cnt = 2**(CNT_W-1) (weakly taken).
- Miss, not taken: no change.
- GHR (MODE=1): ghr <= {ghr[GHR_W-2:0], upd_taken} on every upd_valid. The GHR is non-speculative.

Perf counters:
- perf_lookups +1 when enable & lk_valid.
- perf_mispred +1 when enable & upd_valid & upd_mispredict.
- Both saturate at all-ones; they do not wrap.

Priority:
- rst > clear > update. enable=0 blocks clear, update and the perf counters; rst is unaffected by enable.

Reset (rst=1 at edge, including mid-operation):
- All valid=0, cnt = 2**(CNT_W-1)-1, targets/tags 0, ghr 0, perf counters 0.
- Hence pred_hit=0, pred_taken=0, pred_target=lk_pc+4, pred_idx per lk_pc.

Clear:
- valid=0 and ghr=0 next cycle; counters, targets and perf counters retained.
- A simultaneous update is dropped.

Test Plan:
- After rst, MODE=0, lookup lk_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_idx=0; perf counters 0.
- Update pc=0x100, idx=0, taken, target=0x200 -> next cycle lookup 0x100: hit=1, taken=1 (cnt=2), target=0x200. The same-cycle lookup still misses.
- Counter saturation on pc=0x100:
  - from cnt=2, three not-taken updates -> cnt 1,0,0; hit=1, taken=0, target=0x104.
  - then four taken updates -> cnt saturates at 3, taken=1.
  - a not-taken update to an unallocated pc allocates nothing.
- Alias, IDX_W=6: allocate 0x100 (target 0x200), then a taken update on 0x200 (same idx 0, target 0x300).
  - lookup 0x100 -> miss, target 0x104.
  - lookup 0x200 -> hit, cnt=2, target 0x300.
- MODE=1, GHR_W=6:
  - updates taken, taken, not-taken -> ghr=6'b000110.
  - lookup 0x100 -> pred_idx = 0 ^ 6 = 6.
- Control and saturation:
  - clear and upd_valid in the same cycle -> all entries invalid, update dropped, ghr=0.
  - enable=0 with upd_valid/lk_valid -> no state or perf change.
  - PERF_W=4: 20 mispredicts -> perf_mispred=15.
  - rst mid-stream -> all outputs at reset values next cycle.
